// File: rtl/apb_master.sv
// APB master bridge: valid/ready requests to two APB slaves, one-cycle response pulse.
// Zero-wait latency accept->rsp 3 cycles; req_ready follows PREADY in ACCESS, rsp has no backpressure.
module apb_master #(
  parameter int TIMEOUT = 15
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [8:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic       PREADY1,
  input  logic       PREADY2,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic       write;
    logic       sel2;
    logic [7:0] addr;
    logic [7:0] wdata;
  } hdr_t;

  localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT);

  state_t     state, state_nxt;
  hdr_t       cur, req_hdr;
  logic [7:0] wait_cnt;
  logic [8:0] wait_inc;
  logic       sel_ready;
  logic [7:0] sel_rdata;
  logic       accept, complete, abort;

  assign PWRITE = cur.write;
  assign PADDR  = cur.addr;
  assign PWDATA = cur.wdata;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_hdr   = '{write: req_write, sel2: req_addr[8], addr: req_addr[7:0], wdata: req_wdata};
    sel_ready = cur.sel2 ? PREADY2 : PREADY1;
    sel_rdata = cur.sel2 ? PRDATA2 : PRDATA1;
    wait_inc  = {1'b0, wait_cnt} + 9'd1;
    complete  = (state == ACCESS) && sel_ready;
    abort     = (state == ACCESS) && !sel_ready && (TIMEOUT != 0) && (wait_inc >= TO_LIMIT);
    // req_ready is combinational from PREADY so the next SETUP follows completion directly
    req_ready = (state == IDLE) || complete;
    accept    = req_valid && req_ready;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (complete)   state_nxt = accept ? SETUP : IDLE;
        else if (abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cur       <= '0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      wait_cnt  <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= complete || abort;
      rsp_err   <= abort;
      rsp_rdata <= (complete && !cur.write) ? sel_rdata : 8'h00;
      if (accept) begin
        cur      <= req_hdr;
        PSEL1    <= !req_addr[8];
        PSEL2    <= req_addr[8];
        PENABLE  <= 1'b0;
        wait_cnt <= 8'h00;
      end else if (state == SETUP) begin
        PENABLE <= 1'b1;
      end else if (complete || abort) begin
        PSEL1   <= 1'b0;
        PSEL2   <= 1'b0;
        PENABLE <= 1'b0;
      end else if (state == ACCESS && wait_cnt != 8'hFF) begin
        // saturate so a disabled timeout never wraps the count
        wait_cnt <= wait_inc[7:0];
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed and random transfers against two memory slaves and a
// per-address reference memory; expected timing derived from the wait-state count.
module tb_apb_master;

  localparam int TO = 4;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req_valid, req_ready, req_write;
  logic [8:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic       PREADY1, PREADY2;
  logic [7:0] PRDATA1, PRDATA2;

  apb_master #(.TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY1(PREADY1), .PREADY2(PREADY2), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
  );

  always #5 PCLK = ~PCLK;

  // slave models: stallN low-PREADY cycles per access, byte memories
  int       stall1 = 0, stall2 = 0;
  int       cnt1 = 0, cnt2 = 0;
  bit [7:0] mem1 [256];
  bit [7:0] mem2 [256];
  int       both_sel = 0, psel2_cycles = 0;

  assign PREADY1 = (cnt1 >= stall1);
  assign PREADY2 = (cnt2 >= stall2);
  assign PRDATA1 = mem1[PADDR];
  assign PRDATA2 = mem2[PADDR];

  always @(posedge PCLK) begin
    cnt1 <= (PSEL1 && PENABLE && !PREADY1) ? cnt1 + 1 : 0;
    cnt2 <= (PSEL2 && PENABLE && !PREADY2) ? cnt2 + 1 : 0;
    if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR] <= PWDATA;
    if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR] <= PWDATA;
    if (PSEL1 && PSEL2) both_sel++;
    if (PSEL2) psel2_cycles++;
  end

  // reference: what each address should hold after the transfers issued so far
  bit [7:0] ref_mem [512];
  int       checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // one isolated transfer, called and returning at a falling edge with the DUT idle
  task automatic xfer(input bit wr, input logic [8:0] a, input logic [7:0] d, input int st);
    bit         s2, exp_err;
    int         exp_cyc, n;
    logic [7:0] exp_rd;
    s2      = a[8];
    exp_err = (st >= TO);
    exp_cyc = exp_err ? TO : st + 1;
    exp_rd  = (wr || exp_err) ? 8'h00 : ref_mem[a];
    if (wr && !exp_err) ref_mem[a] = d;
    if (s2) stall2 = st; else stall1 = st;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    chk("req_ready_idle", req_ready, 1);
    @(negedge PCLK);
    req_valid = 1'b0;
    chk("setup_sel", {PSEL1, PSEL2, PENABLE}, {!s2, s2, 1'b0});
    chk("setup_bus", {PWRITE, PADDR, PWDATA}, {wr, a[7:0], d});
    @(negedge PCLK);
    n = 0;
    while (PENABLE && n < 50) begin
      n++;
      chk("access_hold", {PSEL1, PSEL2, PWRITE, PADDR, PWDATA}, {!s2, s2, wr, a[7:0], d});
      chk("no_early_rsp", rsp_valid, 0);
      @(negedge PCLK);
    end
    chk("penable_cycles", n, exp_cyc);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("psel_drop", {PSEL1, PSEL2}, 0);
    @(negedge PCLK);
    chk("rsp_pulse_end", rsp_valid, 0);
  endtask

  logic [8:0] bb_addr [3];
  logic [7:0] bb_dat  [3];
  bit         bb_wr   [3];
  int         rsp_t [$];
  logic [7:0] rsp_d [$];
  int         idx, busy, p2;
  bit         acc;
  bit         rwr;
  logic [8:0] raddr;

  initial begin
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge PCLK);
    chk("reset_outputs", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("reset_req_ready", req_ready, 1);
    PRESET = 1'b0;
    @(negedge PCLK);

    // zero-wait write then read-back on slave 1
    xfer(1'b1, 9'h005, 8'hA5, 0);
    p2 = psel2_cycles;
    xfer(1'b0, 9'h005, 8'h00, 0);
    chk("psel2_never", psel2_cycles - p2, 0);

    // back-to-back with req_valid held
    bb_addr[0] = 9'h003; bb_dat[0] = 8'h01; bb_wr[0] = 1'b1;
    bb_addr[1] = 9'h104; bb_dat[1] = 8'h02; bb_wr[1] = 1'b1;
    bb_addr[2] = 9'h003; bb_dat[2] = 8'h00; bb_wr[2] = 1'b0;
    ref_mem[9'h003] = 8'h01; ref_mem[9'h104] = 8'h02;
    stall1 = 0; stall2 = 0; idx = 0; busy = 0;
    req_valid = 1'b1; req_write = bb_wr[0]; req_addr = bb_addr[0]; req_wdata = bb_dat[0];
    for (int c = 0; c < 30; c++) begin
      acc = req_valid && req_ready;
      @(posedge PCLK);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          req_write = bb_wr[idx]; req_addr = bb_addr[idx]; req_wdata = bb_dat[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge PCLK);
      if (rsp_valid) begin
        rsp_t.push_back(c);
        rsp_d.push_back(rsp_rdata);
      end
      if (PSEL1 || PSEL2) busy++;
    end
    chk("b2b_rsp_count", rsp_t.size(), 3);
    if (rsp_t.size() == 3) begin
      chk("b2b_first_rsp", rsp_t[0], 2);
      chk("b2b_spacing_1", rsp_t[1] - rsp_t[0], 2);
      chk("b2b_spacing_2", rsp_t[2] - rsp_t[1], 2);
      chk("b2b_read_data", rsp_d[2], 8'h01);
      chk("b2b_no_idle", busy, rsp_t[2]);
    end

    // wait states on slave 2
    xfer(1'b1, 9'h110, 8'h3C, 0);
    xfer(1'b0, 9'h110, 8'h5A, 3);

    // stuck slave 1 aborts, next request is normal
    xfer(1'b1, 9'h020, 8'h77, 1000);
    xfer(1'b0, 9'h020, 8'h00, 0);

    // reset in the ACCESS cycle of a write
    stall1 = 1000;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h007; req_wdata = 8'h99;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    chk("pre_reset_access", {PSEL1, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1 chk("async_reset", {PSEL1, PSEL2, PENABLE, rsp_valid}, 0);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    chk("post_reset_idle", {PSEL1, PSEL2, PENABLE, rsp_valid, req_ready}, 5'b00001);
    @(negedge PCLK);
    chk("no_lost_rsp", rsp_valid, 0);
    xfer(1'b1, 9'h007, 8'h99, 0);

    // random transfers, including timeouts
    for (int i = 0; i < 40; i++) begin
      rwr   = 1'($urandom_range(0, 1));
      raddr = (9'($urandom_range(0, 1)) << 8) | 9'($urandom_range(0, 7));
      xfer(rwr, raddr, 8'($urandom_range(0, 255)), int'($urandom_range(0, 5)));
    end

    chk("psel_exclusive", both_sel, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB master bridge that turns a simple valid/ready request port into APB transfers to two slaves, and returns a one-cycle response pulse. It drives PSEL/PENABLE/PWRITE/PADDR/PWDATA into the slaves directly downstream, whose PREADY and PRDATA it consumes. Transfers can run back-to-back with no idle cycle between them. A bounded wait-state timeout keeps the master from hanging on a stuck slave.

## Interface
- TIMEOUT, 15, maximum ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout.
- PCLK  in  1  single clock; all state changes on its rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  9  bit 8 selects the slave (0 = slave 1, 1 = slave 2); bits 7:0 go to PADDR.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  8  read data; 0 for writes and errors.
- rsp_err  out  1  timeout abort; valid with rsp_valid.
- PSEL1, PSEL2  out  1 each  slave selects; at most one is high.
- PENABLE, PWRITE  out  1 each  APB control.
- PADDR, PWDATA  out  8 each  APB address and write data.
- PREADY1, PREADY2  in  1 each  slave ready.
- PRDATA1, PRDATA2  in  8 each  slave read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset enters IDLE.
- req_ready is high in IDLE. It is also high in ACCESS when the selected slave's PREADY is 1, as a combinational path from PREADY. It is low otherwise.
- On accept (req_valid & req_ready): latch write, addr, wdata, and slave select; go to SETUP.
- IDLE to SETUP on accept; otherwise stay in IDLE.
- SETUP to ACCESS, unconditionally, after one cycle.
- ACCESS with selected PREADY=1 (transfer completes):
  - go to SETUP if a new request is accepted the same cycle;
  - otherwise go to IDLE.
- ACCESS with PREADY=0: stay in ACCESS and increment the wait counter.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT, abort and go to IDLE.
- Only the selected slave's PREADY/PRDATA are observed; the other slave's are ignored.
- The wait counter is 8 bits, cleared on entry to SETUP, and saturates rather than wrapping.

## Timing
- All outputs are registered except req_ready.
- Reset values: PSEL1, PSEL2, PENABLE, PWRITE = 0; PADDR, PWDATA = 0x00; rsp_valid, rsp_err = 0; rsp_rdata = 0x00.
- Request accepted at edge N:
  - cycle N+1 (SETUP): PSELx=1, PENABLE=0; PADDR, PWDATA, PWRITE are stable.
  - cycle N+2 (ACCESS): PENABLE=1.
- Completion edge: the first ACCESS edge with PREADY=1.
  - PRDATA is sampled on that edge.
  - rsp_valid=1 in the following cycle only.
  - Zero-wait transfer: accept at N, rsp_valid in cycle N+3.
- PADDR, PWDATA, PWRITE, and PSELx hold constant from SETUP through the completion edge.
- Back-to-back transfer: the cycle after completion is the next SETUP. In it, PENABLE=0, PSELx follows the new slave, and the address/data update.
- When the two consecutive slaves differ, the old PSEL drops in the same cycle the new PSEL rises.
- After a completion or abort with no pending request: PSELx=0 and PENABLE=0 in the next cycle; PADDR and PWDATA hold their last values.
- Timeout: at the edge where the wait count equals TIMEOUT:
  - drop PSELx and PENABLE;
  - next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - With TIMEOUT=15 and PREADY held low: PENABLE is high for exactly 15 cycles.
- PRESET asserted mid-transfer: all outputs go to their reset values immediately (asynchronous); no response is issued for the lost transfer.
- rsp_valid has no backpressure; the consumer must accept it.

## Test plan
- Write 0xA5 to req_addr 0x005 with zero waits:
  - PSEL1=1, PADDR=0x05, PWDATA=0xA5, PWRITE=1 for 2 cycles; PENABLE high in the 2nd only;
  - rsp_valid 3 cycles after accept, rsp_err=0.
- Read req_addr 0x005 after that write: rsp_rdata=0xA5 and rsp_err=0; PSEL2 never high.
- Back-to-back, req_valid held continuously: write 0x01 to 0x003, write 0x02 to 0x104, then read 0x003.
  - No IDLE cycle between transfers; three rsp_valid pulses spaced 2 cycles apart;
  - the read returns 0x01; PSEL1 and PSEL2 are never high together.
- Read from 0x110 with PREADY2 held low for 3 ACCESS cycles, PRDATA2=0x3C:
  - PENABLE high for 4 cycles; rsp_rdata=0x3C; address held stable throughout.
- TIMEOUT=4, PREADY1 tied low:
  - abort after 4 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0x00;
  - the next request proceeds normally.
- Assert PRESET in the ACCESS cycle of a write:
  - PSEL1, PENABLE, rsp_valid go to 0 without waiting for a PCLK edge; FSM is in IDLE after release;
  - the next request starts with a SETUP cycle.
